ball_motion: RTL and testbench

//  Upstream of the hole-capture checks: integrates board tilt into ball velocity and position once per

---
 rtl/ball_motion.sv | 194 +++++++++++++++++++
 tb/tb_ball_motion.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Ball motion integrator: tilt -> velocity -> position per frame.
// Damped wall bounce, freeze on capture, restart to start point.
module ball_motion #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int RADIUS   = 16,
  parameter int START_X  = 32,
  parameter int START_Y  = 32,
  parameter int FRAC     = 4,
  parameter int VMAX     = 6
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       is_game_playing,
  input  logic       i_restart,
  input  logic       i_fall_in,
  input  logic [3:0] i_tilt_x,
  input  logic [3:0] i_tilt_y,
  output logic [9:0] o_bl_x,
  output logic [9:0] o_bl_y,
  output logic       o_pos_valid,
  output logic       o_bounce,
  output logic       o_frozen
);

  localparam int PW = 10 + FRAC;
  localparam int VW = FRAC + 4;

  localparam logic signed [PW+1:0] P_LO =
    (PW+2)'(RADIUS << FRAC);
  localparam logic signed [PW+1:0] P_HX =
    (PW+2)'((SCREEN_W - 1 - RADIUS) << FRAC);
  localparam logic signed [PW+1:0] P_HY =
    (PW+2)'((SCREEN_H - 1 - RADIUS) << FRAC);
  localparam logic signed [VW:0] V_LIM =
    (VW+1)'(VMAX << FRAC);
  localparam logic [PW-1:0] P_SX =
    PW'(START_X << FRAC);
  localparam logic [PW-1:0] P_SY =
    PW'(START_Y << FRAC);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } state_t;

  state_t state;
  logic [1:0] stg;
  logic signed [3:0] tx_q, ty_q;
  logic signed [VW-1:0] vx, vy;
  logic [PW-1:0] px, py;

  logic signed [VW-1:0] nvx, nvy, bvx, bvy;
  logic [PW-1:0] npx, npy;
  logic hx, hy;

  function automatic logic signed [VW-1:0] vel_step(
    input logic signed [VW-1:0] v,
    input logic signed [3:0]    a
  );
    logic signed [VW:0] s;
    logic signed [VW:0] one;
    one = {{VW{1'b0}}, 1'b1};
    s = {v[VW-1], v};
    if (a == 4'sd0) begin
      if (v[VW-1])
        s = s + one;
      else if (|v)
        s = s - one;
    end else begin
      s = s + $signed({{(VW-3){a[3]}}, a});
    end
    if (s > V_LIM)
      s = V_LIM;
    else if (s < -V_LIM)
      s = -V_LIM;
    return s[VW-1:0];
  endfunction

  // Result packs {hit, new position, new velocity}.
  function automatic logic [PW+VW:0] pos_step(
    input logic [PW-1:0]        p,
    input logic signed [VW-1:0] v,
    input logic signed [PW+1:0] hi
  );
    logic signed [PW+1:0] s;
    logic signed [VW-1:0] vh;
    logic lo_hit, hi_hit;
    logic [PW+VW:0] r;
    s = $signed({2'b00, p}) +
        $signed({{(PW+2-VW){v[VW-1]}}, v});
    lo_hit = (s < P_LO);
    hi_hit = (s > hi);
    vh = -(v >>> 1);
    unique case (1'b1)
      lo_hit:  r = {1'b1, P_LO[PW-1:0], vh};
      hi_hit:  r = {1'b1, hi[PW-1:0], vh};
      default: r = {1'b0, s[PW-1:0], v};
    endcase
    return r;
  endfunction

  // Next velocity and clamped next position for both axes.
  always_comb begin
    nvx = vel_step(vx, tx_q);
    nvy = vel_step(vy, ty_q);
    {hx, npx, bvx} = pos_step(px, vx, P_HX);
    {hy, npy, bvy} = pos_step(py, vy, P_HY);
  end

  // Control FSM and the three-step tick/velocity/position pipe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      stg         <= 2'd0;
      tx_q        <= 4'sd0;
      ty_q        <= 4'sd0;
      vx          <= '0;
      vy          <= '0;
      px          <= P_SX;
      py          <= P_SY;
      o_bl_x      <= 10'(START_X);
      o_bl_y      <= 10'(START_Y);
      o_pos_valid <= 1'b0;
      o_bounce    <= 1'b0;
      o_frozen    <= 1'b0;
    end else begin
      o_pos_valid <= 1'b0;
      o_bounce    <= 1'b0;
      if (i_restart) begin
        state    <= is_game_playing ? RUN : IDLE;
        stg      <= 2'd0;
        vx       <= '0;
        vy       <= '0;
        px       <= P_SX;
        py       <= P_SY;
        o_bl_x   <= 10'(START_X);
        o_bl_y   <= 10'(START_Y);
        o_frozen <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (is_game_playing)
              state <= RUN;
          end
          RUN: begin
            if (i_fall_in) begin
              state    <= FROZEN;
              stg      <= 2'd0;
              o_frozen <= 1'b1;
            end else if (!is_game_playing) begin
              state <= IDLE;
              stg   <= 2'd0;
            end else begin
              unique case (stg)
                2'd0: begin
                  if (i_frame_tick) begin
                    tx_q <= i_tilt_x;
                    ty_q <= i_tilt_y;
                    stg  <= 2'd1;
                  end
                end
                2'd1: begin
                  vx  <= nvx;
                  vy  <= nvy;
                  stg <= 2'd2;
                end
                2'd2: begin
                  px          <= npx;
                  py          <= npy;
                  vx          <= bvx;
                  vy          <= bvy;
                  o_bl_x      <= npx[PW-1:FRAC];
                  o_bl_y      <= npy[PW-1:FRAC];
                  o_pos_valid <= 1'b1;
                  o_bounce    <= hx | hy;
                  stg         <= 2'd0;
                end
                default: stg <= 2'd0;
              endcase
            end
          end
          FROZEN: begin
            stg <= 2'd0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion.
// Walls, friction, freeze, restart and reset abort.
module tb_ball_motion;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_frame_tick = 1'b0;
  logic       is_game_playing = 1'b0;
  logic       i_restart = 1'b0;
  logic       i_fall_in = 1'b0;
  logic [3:0] i_tilt_x = 4'd0;
  logic [3:0] i_tilt_y = 4'd0;
  logic [9:0] o_bl_x, o_bl_y;
  logic       o_pos_valid, o_bounce, o_frozen;

  int checks = 0;
  int failures = 0;
  logic [31:0] cur_x, cur_y, cur_b;

  ball_motion dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_frame_tick   (i_frame_tick),
    .is_game_playing(is_game_playing),
    .i_restart      (i_restart),
    .i_fall_in      (i_fall_in),
    .i_tilt_x       (i_tilt_x),
    .i_tilt_y       (i_tilt_y),
    .o_bl_x         (o_bl_x),
    .o_bl_y         (o_bl_y),
    .o_pos_valid    (o_pos_valid),
    .o_bounce       (o_bounce),
    .o_frozen       (o_frozen)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic tick_run(input string tag);
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    chk({tag, "_v0"}, o_pos_valid, 0);
    step();
    chk({tag, "_v1"}, o_pos_valid, 0);
    step();
    chk({tag, "_v2"}, o_pos_valid, 1);
    cur_x = 32'(o_bl_x);
    cur_y = 32'(o_bl_y);
    cur_b = 32'(o_bounce);
    step();
    chk({tag, "_v3"}, o_pos_valid, 0);
  endtask

  task automatic count_valid(input int cyc,
                             output int n);
    n = 0;
    for (int i = 0; i < cyc; i++) begin
      step();
      if (o_pos_valid) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int ey[8];
    ey = '{31, 30, 29, 27, 24, 21, 18, 16};

    @(negedge i_clk);
    step();
    step();
    chk("rst_x", o_bl_x, 32);
    chk("rst_y", o_bl_y, 32);
    chk("rst_valid", o_pos_valid, 0);
    chk("rst_bounce", o_bounce, 0);
    chk("rst_frozen", o_frozen, 0);
    i_rst_n = 1'b1;
    is_game_playing = 1'b1;
    step();
    step();

    // Ramp: vel_x 1..16 LSB.
    i_tilt_x = 4'd1;
    i_tilt_y = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      tick_run("t1");
      chk("t1_x", cur_x, (512 + k * (k + 1) / 2) >> 4);
      chk("t1_y", cur_y, 32);
      chk("t1_b", cur_b, 0);
    end
    chk("t1_final_x", cur_x, 40);

    // Full tilt right until the wall.
    i_tilt_x = 4'd7;
    n = 0;
    seen = 0;
    for (int i = 0; i < 150 && seen == 0; i++) begin
      tick_run("t2");
      n++;
      chk("t2_xmax", 32'(cur_x <= 623), 1);
      if (n == 12) chk("t2_x12", cur_x, 86);
      if (cur_b == 1) seen = 1;
    end
    chk("t2_seen", seen, 1);
    chk("t2_ticks", n, 102);
    chk("t2_wall_x", cur_x, 623);
    chk("t2_wall_y", cur_y, 32);
    i_tilt_x = 4'd0;
    tick_run("t2f");
    chk("t2_after_x", cur_x, 620);
    chk("t2_after_b", cur_b, 0);

    // Full tilt left, bounce at x=16.
    i_tilt_x = 4'b1000;
    n = 0;
    seen = 0;
    for (int i = 0; i < 150 && seen == 0; i++) begin
      tick_run("t3");
      n++;
      chk("t3_xmin", 32'(cur_x >= 16), 1);
      if (cur_b == 1) seen = 1;
    end
    chk("t3_seen", seen, 1);
    chk("t3_ticks", n, 102);
    chk("t3_wall_x", cur_x, 16);
    i_tilt_x = 4'd0;
    tick_run("t3f");
    chk("t3_after1_x", cur_x, 18);
    tick_run("t3g");
    chk("t3_after2_x", cur_x, 21);

    // Capture mid-update, then restart.
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    i_fall_in = 1'b1;
    step();
    i_fall_in = 1'b0;
    chk("t4_frozen", o_frozen, 1);
    count_valid(4, n);
    chk("t4_no_valid", n, 0);
    chk("t4_hold_x", o_bl_x, 21);
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    count_valid(4, n);
    chk("t4_frozen_tick", n, 0);
    chk("t4_still_frozen", o_frozen, 1);
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    chk("t4_rs_x", o_bl_x, 32);
    chk("t4_rs_y", o_bl_y, 32);
    chk("t4_rs_frozen", o_frozen, 0);
    tick_run("t4t");
    chk("t4_tick_x", cur_x, 32);
    chk("t4_tick_y", cur_y, 32);

    // Restart beats a same-cycle tick.
    i_tilt_x = 4'd7;
    i_tilt_y = 4'd7;
    for (int k = 0; k < 4; k++) tick_run("t5a");
    chk("t5_move_x", cur_x, 36);
    chk("t5_move_y", cur_y, 36);
    i_tilt_x = 4'd0;
    i_tilt_y = 4'd0;
    i_restart = 1'b1;
    i_frame_tick = 1'b1;
    step();
    i_restart = 1'b0;
    i_frame_tick = 1'b0;
    chk("t5_rs_x", o_bl_x, 32);
    chk("t5_rs_y", o_bl_y, 32);
    count_valid(4, n);
    chk("t5_no_valid", n, 0);
    tick_run("t5t");
    chk("t5_vel0_x", cur_x, 32);
    chk("t5_vel0_y", cur_y, 32);

    // Reset during the velocity step.
    i_tilt_x = 4'd7;
    i_tilt_y = 4'd7;
    for (int k = 0; k < 4; k++) tick_run("t6a");
    chk("t6_move_x", cur_x, 36);
    i_frame_tick = 1'b1;
    step();
    i_frame_tick = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_x", o_bl_x, 32);
    chk("t6_rst_y", o_bl_y, 32);
    chk("t6_rst_valid", o_pos_valid, 0);
    chk("t6_rst_frozen", o_frozen, 0);
    @(negedge i_clk);
    step();
    is_game_playing = 1'b0;
    i_rst_n = 1'b1;
    step();
    n = 0;
    for (int k = 0; k < 3; k++) begin
      int m;
      i_frame_tick = 1'b1;
      step();
      i_frame_tick = 1'b0;
      count_valid(3, m);
      n += m;
    end
    chk("t6_idle_valid", n, 0);
    chk("t6_idle_x", o_bl_x, 32);

    // Top wall on the y axis.
    is_game_playing = 1'b1;
    step();
    step();
    i_tilt_x = 4'd0;
    i_tilt_y = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      tick_run("t7");
      chk("t7_y", cur_y, 32'(ey[k]));
      chk("t7_x", cur_x, 32);
      chk("t7_b", cur_b, (k == 7) ? 1 : 0);
    end
    i_tilt_y = 4'd0;
    tick_run("t7f");
    chk("t7_after_y", cur_y, 17);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
